l2_bus_responder: RTL and testbench

- L2-side responder for the L1 miss-handler bus: receives `*_mem_en` / `*_mem_wr_en` / address / write-data requests from two L1 requesters (port 0 I-cache, port 1 D-cache).
- Arbitrates between them round-robin, then performs the word access on an internal L2 data array after a fixed latency.
- Answers with the one-cycle `rd_granted` / `wr_granted` pulses and read data that the L1 miss handler waits on.
- Sits between the L1 caches and main memory in the 32b MIPS memory hierarchy.

---
 rtl/l2_bus_responder_if.sv | 34 +++
 rtl/l2_bus_responder.sv | 145 ++++++++++++++
 tb/tb_l2_bus_responder.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/l2_bus_responder_if.sv
// L1 miss-handler <-> L2 responder bus: two request ports (0 = I-cache, 1 = D-cache),
// per-port completion pulses and a shared read-data return.
interface l2_bus_responder_if;
  logic        p0_mem_en;
  logic        p0_mem_wr_en;
  logic [31:0] p0_mem_access_addr;
  logic [31:0] p0_mem_wr_data;
  logic        p0_rd_granted;
  logic        p0_wr_granted;

  logic        p1_mem_en;
  logic        p1_mem_wr_en;
  logic [31:0] p1_mem_access_addr;
  logic [31:0] p1_mem_wr_data;
  logic        p1_rd_granted;
  logic        p1_wr_granted;

  logic [31:0] l2_mem_rd_data;
  logic        l2_addr_err;

  modport master (
    output p0_mem_en, p0_mem_wr_en, p0_mem_access_addr, p0_mem_wr_data,
    output p1_mem_en, p1_mem_wr_en, p1_mem_access_addr, p1_mem_wr_data,
    input  p0_rd_granted, p0_wr_granted, p1_rd_granted, p1_wr_granted,
    input  l2_mem_rd_data, l2_addr_err
  );

  modport slave (
    input  p0_mem_en, p0_mem_wr_en, p0_mem_access_addr, p0_mem_wr_data,
    input  p1_mem_en, p1_mem_wr_en, p1_mem_access_addr, p1_mem_wr_data,
    output p0_rd_granted, p0_wr_granted, p1_rd_granted, p1_wr_granted,
    output l2_mem_rd_data, l2_addr_err
  );
endinterface

// File: rtl/l2_bus_responder.sv
// Two-port round-robin L2 responder with fixed-latency word array access.
// Optional L2_BUS_ADDR_CHECK_EN: out-of-range addresses flagged instead of wrapping.
module l2_bus_responder #(
  parameter int unsigned NUM_WORDS  = 4096,
  parameter int unsigned ACCESS_LAT = 4
) (
  input  logic               clk,
  input  logic               rst,
  l2_bus_responder_if.slave  bus
);

  localparam int unsigned IDX_W = $clog2(NUM_WORDS);
  localparam int unsigned CNT_W = (ACCESS_LAT > 1) ? $clog2(ACCESS_LAT) : 1;

  typedef enum logic [1:0] {IDLE, ACCESS, RESP, GAP} state_t;

  state_t             state, state_nxt;
  logic               last_port;
  logic               lat_port;
  logic               lat_wr;
  logic               lat_bad;
  logic [IDX_W-1:0]   lat_idx;
  logic [31:0]        lat_data;
  logic [CNT_W-1:0]   cnt;

  logic               p0_rd_q, p0_wr_q, p1_rd_q, p1_wr_q;
  logic [31:0]        rd_data_q;

  logic [31:0]        mem [NUM_WORDS];

  logic               accept;
  logic               sel_port;
  logic               sel_wr;
  logic               sel_bad;
  logic [31:0]        sel_addr;
  logic [31:0]        sel_data;
  logic               commit;
  logic               unused_addr_bits;

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    sel_port  = 1'b0;
    case (state)
      IDLE: begin
        if (bus.p0_mem_en || bus.p1_mem_en) begin
          accept    = 1'b1;
          // On a tie the port not served last wins.
          sel_port  = (bus.p0_mem_en && bus.p1_mem_en) ? ~last_port : bus.p1_mem_en;
          state_nxt = ACCESS;
        end
      end
      ACCESS:  if (cnt == '0) state_nxt = RESP;
      RESP:    state_nxt = GAP;
      GAP:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign sel_wr   = sel_port ? bus.p1_mem_wr_en       : bus.p0_mem_wr_en;
  assign sel_addr = sel_port ? bus.p1_mem_access_addr : bus.p0_mem_access_addr;
  assign sel_data = sel_port ? bus.p1_mem_wr_data     : bus.p0_mem_wr_data;
  assign commit   = (state == ACCESS) && (cnt == '0);

`ifdef L2_BUS_ADDR_CHECK_EN
  assign sel_bad = |sel_addr[31:IDX_W+2];
`else
  assign sel_bad = 1'b0;
`endif

  assign unused_addr_bits = ^{sel_addr[1:0], sel_addr[31:IDX_W+2]};

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_port <= 1'b1;
      lat_port  <= 1'b0;
      lat_wr    <= 1'b0;
      lat_bad   <= 1'b0;
      lat_idx   <= '0;
      lat_data  <= '0;
      cnt       <= '0;
      p0_rd_q   <= 1'b0;
      p0_wr_q   <= 1'b0;
      p1_rd_q   <= 1'b0;
      p1_wr_q   <= 1'b0;
      rd_data_q <= '0;
    end else begin
      p0_rd_q <= 1'b0;
      p0_wr_q <= 1'b0;
      p1_rd_q <= 1'b0;
      p1_wr_q <= 1'b0;
      if (accept) begin
        last_port <= sel_port;
        lat_port  <= sel_port;
        lat_wr    <= sel_wr;
        lat_bad   <= sel_bad;
        lat_idx   <= sel_addr[IDX_W+1:2];
        lat_data  <= sel_data;
        cnt       <= CNT_W'(ACCESS_LAT - 1);
      end else if ((state == ACCESS) && (cnt != '0)) begin
        cnt <= cnt - CNT_W'(1);
      end
      // Grants are registered so they appear exactly in the RESP cycle.
      if (commit) begin
        if (lat_wr) begin
          p0_wr_q <= ~lat_port;
          p1_wr_q <= lat_port;
        end else begin
          p0_rd_q   <= ~lat_port;
          p1_rd_q   <= lat_port;
          rd_data_q <= lat_bad ? 32'hDEAD_BEEF : mem[lat_idx];
        end
      end
    end
  end

  // Array has no reset; a write reaching its commit edge under reset is dropped.
  always_ff @(posedge clk) begin
    if (!rst && commit && lat_wr && !lat_bad)
      mem[lat_idx] <= lat_data;
  end

`ifdef L2_BUS_ADDR_CHECK_EN
  logic addr_err_q;
  always_ff @(posedge clk) begin
    if (rst) addr_err_q <= 1'b0;
    else     addr_err_q <= commit && lat_bad;
  end
  assign bus.l2_addr_err = addr_err_q;
`else
  assign bus.l2_addr_err = 1'b0;
`endif

  assign bus.p0_rd_granted  = p0_rd_q;
  assign bus.p0_wr_granted  = p0_wr_q;
  assign bus.p1_rd_granted  = p1_rd_q;
  assign bus.p1_wr_granted  = p1_wr_q;
  assign bus.l2_mem_rd_data = rd_data_q;

endmodule

// File: tb/tb_l2_bus_responder.sv
// Scoreboard bench for l2_bus_responder; covers wrap or L2_BUS_ADDR_CHECK_EN range check.
module tb_l2_bus_responder;

  localparam int LAT = 4;
  localparam int NW  = 4096;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;

  l2_bus_responder_if bus ();

  l2_bus_responder #(.NUM_WORDS(NW), .ACCESS_LAT(LAT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit          port;
    bit          wr;
    logic [31:0] data;
    bit          err;
    int          gcyc;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] mdl [int];
  logic [31:0] last_rd = '0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int idx(input logic [31:0] a);
    return int'((a >> 2) % NW);
  endfunction

  function automatic bit is_bad(input logic [31:0] a);
`ifdef L2_BUS_ADDR_CHECK_EN
    return (a >> 2) >= NW;
`else
    return 1'b0;
`endif
  endfunction

  // Reference model: applies the access in grant order and returns the expectation.
  function automatic exp_t mk_exp(input bit p, input bit wr, input logic [31:0] a,
                                  input logic [31:0] d, input int gc);
    exp_t e;
    e.port = p; e.wr = wr; e.gcyc = gc; e.err = is_bad(a);
    if (wr) begin
      if (!e.err) mdl[idx(a)] = d;
      e.data = last_rd;
    end else begin
      e.data  = e.err ? 32'hDEAD_BEEF : (mdl.exists(idx(a)) ? mdl[idx(a)] : 32'hxxxx_xxxx);
      last_rd = e.data;
    end
    return e;
  endfunction

  task automatic at_cycle(input int n);
    while (cyc < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive(input bit p, input bit en, input bit wr, input logic [31:0] a,
                       input logic [31:0] d);
    if (p) begin
      bus.p1_mem_en = en; bus.p1_mem_wr_en = wr;
      bus.p1_mem_access_addr = a; bus.p1_mem_wr_data = d;
    end else begin
      bus.p0_mem_en = en; bus.p0_mem_wr_en = wr;
      bus.p0_mem_access_addr = a; bus.p0_mem_wr_data = d;
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_p0_rd"}, {31'b0, bus.p0_rd_granted}, 32'd0);
    chk({tag, "_p0_wr"}, {31'b0, bus.p0_wr_granted}, 32'd0);
    chk({tag, "_p1_rd"}, {31'b0, bus.p1_rd_granted}, 32'd0);
    chk({tag, "_p1_wr"}, {31'b0, bus.p1_wr_granted}, 32'd0);
    chk({tag, "_rd_data"}, bus.l2_mem_rd_data, 32'd0);
    chk({tag, "_addr_err"}, {31'b0, bus.l2_addr_err}, 32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    at_cycle(cyc + 2);
    check_idle_outputs("reset");
    rst = 1'b0;
    last_rd = '0;
  endtask

  task automatic single(input bit p, input bit wr, input logic [31:0] a, input logic [31:0] d);
    int c0;
    c0 = cyc;
    sb.push_back(mk_exp(p, wr, a, d, c0 + LAT + 1));
    drive(p, 1'b1, wr, a, d);
    at_cycle(c0 + LAT + 1);
    drive(p, 1'b0, 1'b0, '0, '0);
    at_cycle(c0 + LAT + 3);
  endtask

  always @(negedge clk) begin : monitor
    int   ng;
    exp_t e;
    ng = int'(bus.p0_rd_granted) + int'(bus.p0_wr_granted)
       + int'(bus.p1_rd_granted) + int'(bus.p1_wr_granted);
    if (ng != 0) begin
      chk("one_grant", ng, 1);
      if (sb.size() == 0) begin
        chk("unexpected_grant", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        chk("grant_port", {31'b0, bus.p1_rd_granted | bus.p1_wr_granted}, {31'b0, e.port});
        chk("grant_wr",   {31'b0, bus.p0_wr_granted | bus.p1_wr_granted}, {31'b0, e.wr});
        chk("grant_cycle", cyc, e.gcyc);
        chk("rd_data",    bus.l2_mem_rd_data, e.data);
        chk("addr_err",   {31'b0, bus.l2_addr_err}, {31'b0, e.err});
      end
    end else if (!rst && bus.l2_addr_err !== 1'b0) begin
      chk("err_without_grant", {31'b0, bus.l2_addr_err}, 32'd0);
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "bench timeout");
  end

  initial begin : stim
    int c0;
    drive(1'b0, 1'b0, 1'b0, '0, '0);
    drive(1'b1, 1'b0, 1'b0, '0, '0);
    @(posedge clk);
    #1;
    do_reset();

    // Basic write then read, plus byte-offset bits ignored.
    single(1'b0, 1'b1, 32'h40, 32'h1234_5678);
    single(1'b0, 1'b0, 32'h40, '0);
    single(1'b1, 1'b0, 32'h43, '0);

    // Preload, reset (array kept), then simultaneous requests: port 0 first.
    single(1'b1, 1'b1, 32'h100, 32'h0BAD_F00D);
    single(1'b0, 1'b1, 32'h200, 32'h600D_CAFE);
    do_reset();
    c0 = cyc;
    sb.push_back(mk_exp(1'b0, 1'b0, 32'h100, '0, c0 + LAT + 1));
    sb.push_back(mk_exp(1'b1, 1'b0, 32'h200, '0, c0 + 2 * LAT + 4));
    drive(1'b0, 1'b1, 1'b0, 32'h100, '0);
    drive(1'b1, 1'b1, 1'b0, 32'h200, '0);
    at_cycle(c0 + LAT + 1);
    drive(1'b0, 1'b0, 1'b0, '0, '0);
    at_cycle(c0 + 2 * LAT + 4);
    drive(1'b1, 1'b0, 1'b0, '0, '0);
    at_cycle(c0 + 2 * LAT + 6);

    // Port 1 holds en back-to-back; port 0 arrives mid-access: order 1, 0, 1.
    c0 = cyc;
    sb.push_back(mk_exp(1'b1, 1'b0, 32'h100, '0, c0 + LAT + 1));
    sb.push_back(mk_exp(1'b0, 1'b0, 32'h40,  '0, c0 + 2 * LAT + 4));
    sb.push_back(mk_exp(1'b1, 1'b0, 32'h200, '0, c0 + 3 * LAT + 7));
    drive(1'b1, 1'b1, 1'b0, 32'h100, '0);
    at_cycle(c0 + 2);
    drive(1'b0, 1'b1, 1'b0, 32'h40, '0);
    at_cycle(c0 + LAT + 1);
    drive(1'b1, 1'b1, 1'b0, 32'h200, '0);
    at_cycle(c0 + 2 * LAT + 4);
    drive(1'b0, 1'b0, 1'b0, '0, '0);
    at_cycle(c0 + 3 * LAT + 7);
    drive(1'b1, 1'b0, 1'b0, '0, '0);
    at_cycle(c0 + 3 * LAT + 9);

    // Reset during ACCESS drops an uncommitted write.
    single(1'b0, 1'b1, 32'h80, 32'h5555_5555);
    c0 = cyc;
    drive(1'b0, 1'b1, 1'b1, 32'h80, 32'hAAAA_AAAA);
    at_cycle(c0 + 2);
    rst = 1'b1;
    at_cycle(c0 + 3);
    rst = 1'b0;
    drive(1'b0, 1'b0, 1'b0, '0, '0);
    check_idle_outputs("after_rst");
    last_rd = '0;
    at_cycle(c0 + LAT + 4);
    single(1'b0, 1'b0, 32'h80, '0);

    // High address bits: wrap by default, flagged with the range check.
    single(1'b1, 1'b1, 32'h4, 32'h7777_0004);
    single(1'b1, 1'b1, 32'h0001_0004, 32'hCAFE_0001);
    single(1'b0, 1'b0, 32'h0001_0004, '0);
    single(1'b0, 1'b0, 32'h4, '0);

    at_cycle(cyc + 3);
    chk("sb_drained", sb.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
